dma_burst_legalizer: RTL and testbench
======================================

Name: dma_burst_legalizer

Overview:
Splits cluster DMA transfer requests (start address, byte length, ID) into legal AXI burst commands for the SoC-side port. Each burst is capped at a configurable maximum byte size, never crosses an address boundary, and is issued only while the outstanding-transaction budget allows. Sits between the DMA frontend and the AXI AR/AW issue logic. Bus width, burst cap, boundary and in-flight depth are all parametrised.

Parameters:
AddrWidth, 32, address width [bit]
DataWidth, 64, SoC bus data width [bit]; power of 2, >= 8
LenWidth, 24, transfer byte-length width [bit]
IdWidth, 4, transfer ID width [bit]
MaxBurstBytes, 2048, maximum burst size [B]; power of 2, >= DataWidth/8, burst beats <= 256
BoundaryBytes, 4096, no burst may cross a multiple of this [B]; power of 2
MaxTxns, 64, maximum bursts in flight; >= 1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  transfer request valid
req_ready_o  out  1  transfer request ready
req_addr_i  in  AddrWidth  start byte address
req_len_i  in  LenWidth  length in bytes
req_id_i  in  IdWidth  transfer ID
burst_valid_o  out  1  burst command valid
burst_ready_i  in  1  burst command ready
burst_addr_o  out  AddrWidth  burst start address
burst_len_o  out  8  AXI len (beats-1)
burst_size_o  out  3  AXI size, log2(DataWidth/8)
burst_id_o  out  IdWidth  ID of parent transfer
burst_last_o  out  1  final burst of the transfer
cmpl_i  in  1  one burst completed (B/last R); one pulse per burst
err_o  out  1  one-cycle pulse: request rejected
busy_o  out  1  FSM in SPLIT
outstanding_o  out  $clog2(MaxTxns+1)  bursts in flight

Behaviour:
- Reset: FSM IDLE; req_ready_o=1, burst_valid_o=0, burst_last_o=0, err_o=0, busy_o=0, outstanding_o=0; burst_addr/len/id registers 0; burst_size_o constant.
- FSM IDLE: req_ready_o=1. On req handshake: if req_len_i==0, or addr or len not multiple of DataWidth/8 -> err_o=1 next cycle, stay IDLE, no bursts; else latch cur_addr, remaining, id -> SPLIT.
- FSM SPLIT: req_ready_o=0, busy_o=1. Burst bytes B = min(remaining, MaxBurstBytes - cur_addr mod MaxBurstBytes, BoundaryBytes - cur_addr mod BoundaryBytes). burst_len_o = B/(DataWidth/8) - 1; burst_last_o = (B == remaining).
- First burst_valid_o no earlier than cycle after request acceptance (1-cycle latency); command fields are registered/derived from registers only.
- burst_valid_o = SPLIT and outstanding_o < MaxTxns. Once asserted, valid and all fields held stable until burst_ready_i (AXI rule); budget cannot shrink while valid since only completions change it downward.
- On burst handshake: cur_addr += B, remaining -= B, outstanding +1; if burst_last_o -> IDLE (next request acceptable the following cycle).
- Completion: cmpl_i decrements outstanding. Same-cycle issue and completion -> unchanged. cmpl_i with outstanding 0 ignored (simulation assertion fires). Completions continue to be counted in IDLE.
- Outstanding saturates at MaxTxns by construction; valid deasserts at cap, reasserts cycle after a completion.
- Address arithmetic wraps modulo 2^AddrWidth; crossing top of address space is a caller error (assertion), not checked in RTL.
- Reset mid-transfer: transfer abandoned, counter cleared, no further bursts.

Test Plan:
- DataWidth=64: addr 0x1000, len 4096 -> bursts (0x1000, len 255, last 0), (0x1800, len 255, last 1); outstanding 2.
- addr 0x0FF0, len 64 -> (0x0FF0, len 1), (0x1000, len 5, last 1); boundary not crossed.
- MaxTxns=2, addr 0, len 8192 -> 2 bursts, burst_valid_o low with ready high; cmpl_i pulse -> third burst (0x1000) issues next cycle; all 4 issued after completions.
- Issue handshake coincident with cmpl_i at outstanding 1 -> outstanding stays 1.
- len 0, then addr 0x1004 len 8 -> err_o pulse each, no burst_valid_o, req_ready_o stays 1.
- burst_ready_i low 5 cycles -> fields stable; rst_i mid-transfer (2 of 4 issued) -> all outputs at reset values next cycle, outstanding 0.

Source files
------------

// File: rtl/dma_burst_legalizer.sv
// Splits DMA transfer requests into AXI bursts capped at MaxBurstBytes that never
// cross a BoundaryBytes line, issuing only while the in-flight budget allows.
module dma_burst_legalizer #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 64,
    parameter int LenWidth      = 24,
    parameter int IdWidth       = 4,
    parameter int MaxBurstBytes = 2048,
    parameter int BoundaryBytes = 4096,
    parameter int MaxTxns       = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic [LenWidth-1:0]            req_len_i,
    input  logic [IdWidth-1:0]             req_id_i,
    output logic                           burst_valid_o,
    input  logic                           burst_ready_i,
    output logic [AddrWidth-1:0]           burst_addr_o,
    output logic [7:0]                     burst_len_o,
    output logic [2:0]                     burst_size_o,
    output logic [IdWidth-1:0]             burst_id_o,
    output logic                           burst_last_o,
    input  logic                           cmpl_i,
    output logic                           err_o,
    output logic                           busy_o,
    output logic [$clog2(MaxTxns+1)-1:0]   outstanding_o
);

    localparam int BeatBytes = DataWidth / 8;
    localparam int SizeVal   = $clog2(BeatBytes);
    localparam int CntW      = $clog2(MaxTxns + 1);
    localparam int MbW       = $clog2(MaxBurstBytes) + 1;
    localparam int BdW       = $clog2(BoundaryBytes) + 1;
    localparam int CalcW0    = (LenWidth > MbW) ? LenWidth : MbW;
    localparam int CalcW1    = (CalcW0 > BdW) ? CalcW0 : BdW;
    localparam int CalcW     = (CalcW1 > 9) ? CalcW1 : 9;

    localparam logic [AddrWidth-1:0] MbMask    = AddrWidth'(MaxBurstBytes - 1);
    localparam logic [AddrWidth-1:0] BdMask    = AddrWidth'(BoundaryBytes - 1);
    localparam logic [AddrWidth-1:0] BeatMaskA = AddrWidth'(BeatBytes - 1);
    localparam logic [LenWidth-1:0]  BeatMaskL = LenWidth'(BeatBytes - 1);
    localparam logic [AddrWidth:0]   AddrSpace = {1'b1, {AddrWidth{1'b0}}};

    typedef enum logic {
        IDLE,
        SPLIT
    } state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0] cur_addr_q;
    logic [LenWidth-1:0]  remaining_q;
    logic [IdWidth-1:0]   id_q;
    logic [CntW-1:0]      outstanding_q;
    logic                 err_q;

    logic                 req_hs, req_bad, burst_valid, burst_hs, cmpl_eff;
    logic [CalcW-1:0]     to_max, to_bnd, rem_ext, bytes;
    logic [7:0]           beats_m1;
    logic                 last;
    logic [AddrWidth:0]   end_addr;

    // Burst size is the tightest of: bytes left, room to the burst cap line, room to the boundary.
    always_comb begin
        to_max   = CalcW'(MaxBurstBytes) - CalcW'(cur_addr_q & MbMask);
        to_bnd   = CalcW'(BoundaryBytes) - CalcW'(cur_addr_q & BdMask);
        rem_ext  = CalcW'(remaining_q);
        bytes    = rem_ext;
        if (to_max < bytes) bytes = to_max;
        if (to_bnd < bytes) bytes = to_bnd;
        beats_m1 = 8'((bytes >> SizeVal) - CalcW'(1));
        last     = (bytes == rem_ext);
    end

    always_comb begin
        req_hs      = req_valid_i && (state_q == IDLE);
        req_bad     = (req_len_i == '0) || ((req_addr_i & BeatMaskA) != '0)
                      || ((req_len_i & BeatMaskL) != '0);
        burst_valid = (state_q == SPLIT) && (outstanding_q < CntW'(MaxTxns));
        burst_hs    = burst_valid && burst_ready_i;
        cmpl_eff    = cmpl_i && (outstanding_q != '0);
        end_addr    = {1'b0, req_addr_i} + (AddrWidth + 1)'(req_len_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_hs && !req_bad) state_d = SPLIT;
            SPLIT:   if (burst_hs && last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            id_q          <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            err_q <= req_hs && req_bad;
            if (req_hs && !req_bad) begin
                cur_addr_q  <= req_addr_i;
                remaining_q <= req_len_i;
                id_q        <= req_id_i;
            end else if (burst_hs) begin
                cur_addr_q  <= cur_addr_q + AddrWidth'(bytes);
                remaining_q <= remaining_q - LenWidth'(bytes);
            end
            // Issue and completion in the same cycle cancel out.
            unique case ({burst_hs, cmpl_eff})
                2'b10:   outstanding_q <= outstanding_q + CntW'(1);
                2'b01:   outstanding_q <= outstanding_q - CntW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    always_comb begin
        req_ready_o   = (state_q == IDLE);
        busy_o        = (state_q == SPLIT);
        burst_valid_o = burst_valid;
        burst_addr_o  = cur_addr_q;
        burst_id_o    = id_q;
        burst_len_o   = (state_q == SPLIT) ? beats_m1 : '0;
        burst_last_o  = (state_q == SPLIT) && last;
        burst_size_o  = 3'(SizeVal);
        err_o         = err_q;
        outstanding_o = outstanding_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(cmpl_i && outstanding_q == '0))
                else $error("dma_burst_legalizer: completion with no burst in flight");
            assert (!(req_hs && !req_bad && end_addr > AddrSpace))
                else $error("dma_burst_legalizer: transfer wraps past top of address space");
        end
    end

endmodule

// File: tb/tb_dma_burst_legalizer.sv
// Bench for dma_burst_legalizer: directed and random transfers checked against a
// burst-plan model built from the size/boundary rules and an in-flight count.
module tb_dma_burst_legalizer;

    localparam int MAXT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [23:0] req_len_i;
    logic [3:0]  req_id_i;
    logic        burst_valid_o;
    logic        burst_ready_i;
    logic [31:0] burst_addr_o;
    logic [7:0]  burst_len_o;
    logic [2:0]  burst_size_o;
    logic [3:0]  burst_id_o;
    logic        burst_last_o;
    logic        cmpl_i;
    logic        err_o;
    logic        busy_o;
    logic [1:0]  outstanding_o;

    int checks = 0;
    int errors = 0;
    int model_out = 0;

    logic [31:0] q_addr[$];
    logic [7:0]  q_len[$];
    logic        q_last[$];

    dma_burst_legalizer #(
        .AddrWidth(32), .DataWidth(64), .LenWidth(24), .IdWidth(4),
        .MaxBurstBytes(2048), .BoundaryBytes(4096), .MaxTxns(MAXT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_id_i(req_id_i),
        .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
        .burst_addr_o(burst_addr_o), .burst_len_o(burst_len_o),
        .burst_size_o(burst_size_o), .burst_id_o(burst_id_o),
        .burst_last_o(burst_last_o), .cmpl_i(cmpl_i), .err_o(err_o),
        .busy_o(busy_o), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // Expected burst list for a transfer: each burst is the smallest of the bytes
    // left, the room to the next 2 KiB line and the room to the next 4 KiB line.
    function automatic void plan(input longint unsigned addr, input longint unsigned len);
        longint unsigned b;
        while (len > 0) begin
            b = len;
            if (2048 - addr % 2048 < b) b = 2048 - addr % 2048;
            if (4096 - addr % 4096 < b) b = 4096 - addr % 4096;
            q_addr.push_back(32'(addr));
            q_len.push_back(8'(b / 8 - 1));
            q_last.push_back(b == len);
            addr += b;
            len  -= b;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        check({tag, "_valid"}, 64'(burst_valid_o), 64'd0);
        check({tag, "_last"}, 64'(burst_last_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
        check({tag, "_addr"}, 64'(burst_addr_o), 64'd0);
        check({tag, "_len"}, 64'(burst_len_o), 64'd0);
        check({tag, "_id"}, 64'(burst_id_o), 64'd0);
        check({tag, "_size"}, 64'(burst_size_o), 64'd3);
    endtask

    // ready_mode: 0 always, 1 random, 2 low for the first 5 cycles.
    // cmpl_mode: 0 never, 1 random, 2 whenever something is in flight,
    //            3 only after sitting at the budget cap for 3 cycles.
    // abort_at: nonzero -> assert reset once that many bursts have issued.
    task automatic xfer(input logic [31:0] addr, input logic [23:0] len, input logic [3:0] id,
                        input int ready_mode, input int cmpl_mode, input int abort_at);
        int  cyc;
        int  issued;
        int  stall;
        bit  exp_valid;
        bit  rdy;
        bit  cm;
        cyc = 0; issued = 0; stall = 0;
        plan(64'(addr), 64'(len));
        check("xfer_req_ready", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1; req_addr_i = addr; req_len_i = len; req_id_i = id;
        tick();
        req_valid_i = 1'b0; req_addr_i = $urandom; req_len_i = 24'($urandom); req_id_i = 4'($urandom);
        while (q_addr.size() > 0) begin
            if (cyc >= 3000) begin
                checks++; errors++;
                $error("FAIL xfer_timeout: observed=%0d bursts left expected=0", q_addr.size());
                q_addr.delete(); q_len.delete(); q_last.delete();
                break;
            end
            exp_valid = (model_out < MAXT);
            check("busy", 64'(busy_o), 64'd1);
            check("req_ready_split", 64'(req_ready_o), 64'd0);
            check("outstanding", 64'(outstanding_o), 64'(model_out));
            check("valid", 64'(burst_valid_o), 64'(exp_valid));
            if (exp_valid) begin
                check("burst_addr", 64'(burst_addr_o), 64'(q_addr[0]));
                check("burst_len", 64'(burst_len_o), 64'(q_len[0]));
                check("burst_last", 64'(burst_last_o), 64'(q_last[0]));
                check("burst_id", 64'(burst_id_o), 64'(id));
                check("burst_size", 64'(burst_size_o), 64'd3);
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom % 2) == 0;
                default: rdy = (cyc >= 5);
            endcase
            case (cmpl_mode)
                0:       cm = 1'b0;
                1:       cm = (model_out > 0) && ($urandom % 3 == 0);
                2:       cm = (model_out > 0);
                default: cm = (model_out == MAXT) && (stall >= 3);
            endcase
            stall = (model_out == MAXT) ? stall + 1 : 0;
            burst_ready_i = rdy; cmpl_i = cm;
            tick();
            burst_ready_i = 1'b0; cmpl_i = 1'b0;
            if (exp_valid && rdy) begin
                void'(q_addr.pop_front()); void'(q_len.pop_front()); void'(q_last.pop_front());
                model_out++;
                issued++;
            end
            if (cm) model_out--;
            cyc++;
            if (abort_at != 0 && issued == abort_at) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                check_reset_outputs("midreset");
                model_out = 0;
                q_addr.delete(); q_len.delete(); q_last.delete();
                return;
            end
        end
        check("done_busy", 64'(busy_o), 64'd0);
        check("done_req_ready", 64'(req_ready_o), 64'd1);
        check("done_outstanding", 64'(outstanding_o), 64'(model_out));
    endtask

    task automatic drain();
        while (model_out > 0) begin
            cmpl_i = 1'b1;
            tick();
            cmpl_i = 1'b0;
            model_out--;
            check("drain_outstanding", 64'(outstanding_o), 64'(model_out));
        end
    endtask

    task automatic reject(input logic [31:0] addr, input logic [23:0] len);
        check("rej_req_ready", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1; req_addr_i = addr; req_len_i = len; req_id_i = 4'hF;
        tick();
        req_valid_i = 1'b0;
        check("rej_err", 64'(err_o), 64'd1);
        check("rej_valid", 64'(burst_valid_o), 64'd0);
        check("rej_ready_after", 64'(req_ready_o), 64'd1);
        check("rej_busy", 64'(busy_o), 64'd0);
        tick();
        check("rej_err_clear", 64'(err_o), 64'd0);
        check("rej_valid_later", 64'(burst_valid_o), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [23:0] rl;
        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_len_i = '0; req_id_i = '0;
        burst_ready_i = 1'b0; cmpl_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        check_reset_outputs("reset");

        xfer(32'h0000_1000, 24'd4096, 4'h3, 0, 0, 0);
        check("t1_outstanding_two", 64'(outstanding_o), 64'd2);
        drain();

        xfer(32'h0000_0FF0, 24'd64, 4'h5, 0, 0, 0);
        drain();

        xfer(32'h0000_0000, 24'd8192, 4'h7, 0, 3, 0);
        drain();

        xfer(32'h0000_0000, 24'd4096, 4'h1, 0, 2, 0);
        check("coincident_outstanding", 64'(outstanding_o), 64'd1);
        drain();

        reject(32'h0000_0000, 24'd0);
        reject(32'h0000_1004, 24'd8);
        reject(32'h0000_1000, 24'd12);

        xfer(32'h0000_2000, 24'd4096, 4'h9, 2, 1, 0);
        drain();

        for (int i = 0; i < 25; i++) begin
            ra = $urandom_range(0, 32'h7FFF_0000) & 32'hFFFF_FFF8;
            rl = 24'($urandom_range(1, 1200) * 8);
            xfer(ra, rl, 4'($urandom), 1, 1, 0);
            if ($urandom % 2 == 0) drain();
        end
        drain();

        xfer(32'h0000_0000, 24'd8192, 4'hA, 0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_valid", 64'(burst_valid_o), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
